// File: rtl/dma_rd_engine_pkg.sv
// Shared FSM encoding and default widths for the DMA read engine.
package dma_rd_engine_pkg;

  localparam int DMA_ADDR_W     = 32;
  localparam int DMA_LEN_W      = 16;
  localparam int DMA_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dma_rd_engine_sync_fifo.sv
// Synchronous first-word-fall-through FIFO (module sync_fifo); head is visible
// combinationally on dout whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage is deliberately left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_rd_engine.sv
// Read-side DMA initiator: issues byte reads under a credit limit and streams
// the responses out. Optional stall counter enabled by macro DMA_RD_STATS_EN.
module dma_rd_engine
  import dma_rd_engine_pkg::*;
#(
  parameter int ADDR_W     = DMA_ADDR_W,
  parameter int LEN_W      = DMA_LEN_W,
  parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_resp_valid,
  input  logic [7:0]        rd_resp_data,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
`ifdef DMA_RD_STATS_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic              m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  sent;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic              accept_start;
  logic              issue;
  logic              resp_push;
  logic              pop;

  assign accept_start = (state == IDLE) && start;

  // Requests in flight plus buffered bytes may never exceed the FIFO depth,
  // because the memory cannot be stalled once a request is out.
  assign issue = (state == ISSUE) && (issued < len) &&
                 (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_MAX);

  // Responses with no matching request (left over from before a reset) are dropped.
  assign resp_push = rd_resp_valid && (outstanding != '0) && !fifo_full;

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head : 8'h00;
  assign m_last  = m_valid && (sent == len - LEN_W'(1));
  assign pop     = m_valid && m_ready;
  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length == '0) ? DONE : ISSUE;
      ISSUE:   if (issue && ((issued + LEN_W'(1)) == len)) state_next = DRAIN;
      DRAIN:   if (sent == len) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr    <= '0;
      len         <= '0;
      issued      <= '0;
      sent        <= '0;
      outstanding <= '0;
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
    end else begin
      rd_valid <= issue;
      if (accept_start) begin
        cur_addr <= base_addr;
        len      <= length;
        issued   <= '0;
        sent     <= '0;
      end else begin
        if (issue) begin
          rd_addr  <= cur_addr;
          cur_addr <= cur_addr + ADDR_W'(1);
          issued   <= issued + LEN_W'(1);
        end
        if (pop) begin
          sent <= sent + LEN_W'(1);
        end
      end
      case ({issue, resp_push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef DMA_RD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept_start) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_push),
    .din   (rd_resp_data),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dma_rd_engine.sv
// Self-checking bench for dma_rd_engine with a fixed-latency byte memory model.
module tb_dma_rd_engine;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 8;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [7:0]        rd_resp_data;
  logic              m_valid, m_last;
  logic [7:0]        m_data;
  logic              m_ready = 1'b0;
`ifdef DMA_RD_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_rd_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .rd_valid      (rd_valid),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
`ifdef DMA_RD_STATS_EN
    .stall_cnt     (stall_cnt),
`endif
    .m_ready       (m_ready)
  );

  // Memory contents: every byte is a fold of its address, so wrong or wrapped addresses show.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  logic [LAT-1:0]      pipe_v = '0;
  logic [LAT-1:0][7:0] pipe_d = '0;
  always @(posedge clk) begin
    pipe_v <= {pipe_v[LAT-2:0], rd_valid};
    pipe_d <= {pipe_d[LAT-2:0], mem_byte(rd_addr)};
  end
  assign rd_resp_valid = pipe_v[LAT-1];
  assign rd_resp_data  = pipe_d[LAT-1];

  logic [7:0]  got_data[$];
  logic        got_last[$];
  logic [31:0] got_addr[$];
  int done_cnt, first_done, rd_run_max, mv_run_max, rd_stall_n, max_inflight, hold_err, last_err;

  // Drives one transfer and records everything observed until a few cycles after done.
  // mode 0: m_ready=1, mode 1: random m_ready, mode 2: m_ready=0 for 'stall' cycles.
  task automatic run_xfer(input logic [31:0] base, input logic [15:0] len, input int mode,
                          input int stall, input int busy_start_cyc);
    int cyc = 0;
    int post = -1;
    int rd_run = 0;
    int mv_run = 0;
    int rd_n = 0;
    int pop_n = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cnt = 0; first_done = -1; rd_run_max = 0; mv_run_max = 0;
    rd_stall_n = 0; max_inflight = 0; hold_err = 0; last_err = 0;
    @(posedge clk); #1;
    base_addr = base; length = len; start = 1'b1;
    m_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000 && post != 0) begin
      if (cyc == busy_start_cyc) begin
        start = 1'b1; base_addr = ~base; length = len + 16'd3;
      end else if (cyc == busy_start_cyc + 1) begin
        start = 1'b0;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc < stall) ? 1'b0 : 1'b1;
      endcase
      @(negedge clk);
      if (rd_valid) begin
        got_addr.push_back(rd_addr);
        rd_n++; rd_run++;
        if (cyc < stall) rd_stall_n++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
      end else begin
        rd_run = 0;
      end
      if (m_valid) begin
        mv_run++;
        if (mv_run > mv_run_max) mv_run_max = mv_run;
      end else begin
        mv_run = 0;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_last && !m_valid) last_err++;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        pop_n++;
      end
      if (rd_n - pop_n > max_inflight) max_inflight = rd_n - pop_n;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        if (post < 0) post = 5;
      end
      if (post > 0) post--;
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b1;
    $display("xfer base=%h len=%0d mode=%0d bytes=%0d reads=%0d done_pulses=%0d cycles=%0d",
             base, len, mode, got_data.size(), got_addr.size(), done_cnt, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_valid, m_valid, m_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, rd_valid, m_valid, m_last});
    end
    checks++;
    if (rd_addr !== 32'h0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data rd_addr=%h m_data=%h exp=0", rd_addr, m_data);
    end
`ifdef DMA_RD_STATS_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    run_xfer(32'h10, 16'd4, 0, 0, -1);
    checks++;
    if (got_data.size() !== 4) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=4", got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h10 + 8'(i) || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_byte%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                 8'h10 + 8'(i), (i == 3));
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done_pulses=%0d busy=%b exp=1/0", done_cnt, busy);
    end
  endtask

  task automatic test_throughput();
    run_xfer(32'h0, 16'd16, 0, 0, -1);
    checks++;
    if (rd_run_max !== 16) begin
      errors++;
      $display("FAIL thru_rd_run got=%0d exp=16", rd_run_max);
    end
    checks++;
    if (mv_run_max !== 16) begin
      errors++;
      $display("FAIL thru_mvalid_run got=%0d exp=16", mv_run_max);
    end
    checks++;
    if (got_data.size() !== 16) begin
      errors++;
      $display("FAIL thru_count got=%0d exp=16", got_data.size());
    end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== mem_byte(32'(i))) begin
        errors++;
        $display("FAIL thru_byte%0d got=%h exp=%h", i, got_data[i], mem_byte(32'(i)));
      end
    end
  endtask

  task automatic test_backpressure();
    run_xfer(32'h0, 16'd20, 2, 30, -1);
    checks++;
    if (rd_stall_n !== DEPTH) begin
      errors++;
      $display("FAIL bp_reads_stalled got=%0d exp=%0d", rd_stall_n, DEPTH);
    end
    checks++;
    if (max_inflight > DEPTH) begin
      errors++;
      $display("FAIL bp_inflight got=%0d exp<=%0d", max_inflight, DEPTH);
    end
    checks++;
    if (hold_err !== 0 || last_err !== 0) begin
      errors++;
      $display("FAIL bp_hold hold_err=%0d last_err=%0d exp=0", hold_err, last_err);
    end
    checks++;
    if (got_data.size() !== 20 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_count bytes=%0d done=%0d exp=20/1", got_data.size(), done_cnt);
    end
    for (int i = 0; i < 20 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== mem_byte(32'(i)) || got_last[i] !== (i == 19)) begin
        errors++;
        $display("FAIL bp_byte%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                 mem_byte(32'(i)), (i == 19));
      end
    end
`ifdef DMA_RD_STATS_EN
    checks++;
    if (stall_cnt < 32'd25 || stall_cnt > 32'd30) begin
      errors++;
      $display("FAIL bp_stall_cnt got=%0d exp=25..30", stall_cnt);
    end
`endif
  endtask

  task automatic test_zero_len();
    run_xfer(32'h55, 16'd0, 0, 0, -1);
    checks++;
    if (got_addr.size() !== 0 || mv_run_max !== 0) begin
      errors++;
      $display("FAIL zero_activity reads=%0d mvalid=%0d exp=0/0", got_addr.size(), mv_run_max);
    end
    checks++;
    if (done_cnt !== 1 || first_done !== 0) begin
      errors++;
      $display("FAIL zero_done pulses=%0d at=%0d exp=1 at 0", done_cnt, first_done);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc = 0;
    int mv_seen = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    base_addr = 32'h80; length = 16'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      if (rd_valid) n++;
      cyc++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (n !== 3 || {busy, done, rd_valid, m_valid, m_last} !== 5'b0 || rd_addr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs reads=%0d flags=%b rd_addr=%h exp=3/00000/0",
               n, {busy, done, rd_valid, m_valid, m_last}, rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid || busy) mv_seen++;
    end
    checks++;
    if (mv_seen !== 0) begin
      errors++;
      $display("FAIL midrst_stale got=%0d active cycles exp=0", mv_seen);
    end
    $display("midop reset applied after %0d reads", n);
    run_xfer(32'h40, 16'd2, 0, 0, -1);
    checks++;
    if (got_data.size() !== 2) begin
      errors++;
      $display("FAIL midrst_count got=%0d exp=2", got_data.size());
    end
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h40 + 8'(i)) begin
        errors++;
        $display("FAIL midrst_byte%0d got=%h exp=%h", i, got_data[i], 8'h40 + 8'(i));
      end
    end
  endtask

  task automatic test_start_busy();
    run_xfer(32'h200, 16'd10, 1, 0, 5);
    checks++;
    if (got_data.size() !== 10 || got_addr.size() !== 10 || done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_start bytes=%0d reads=%0d done=%0d exp=10/10/1",
               got_data.size(), got_addr.size(), done_cnt);
    end
    for (int i = 0; i < 10 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== mem_byte(32'h200 + 32'(i))) begin
        errors++;
        $display("FAIL busy_byte%0d got=%h exp=%h", i, got_data[i], mem_byte(32'h200 + 32'(i)));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [31:0] base;
      logic [15:0] len;
      base = $urandom;
      if (t % 3 == 0) base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      len = 16'($urandom_range(1, 40));
      run_xfer(base, len, 1, 0, -1);
      checks++;
      if (got_data.size() !== int'(len) || got_addr.size() !== int'(len) || done_cnt !== 1 ||
          hold_err !== 0 || last_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_summary bytes=%0d reads=%0d done=%0d hold=%0d last=%0d exp len=%0d",
                 t, got_data.size(), got_addr.size(), done_cnt, hold_err, last_err, len);
      end
      for (int i = 0; i < int'(len) && i < got_data.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== base + 32'(i) || got_data[i] !== mem_byte(base + 32'(i)) ||
            got_last[i] !== (i == int'(len) - 1)) begin
          errors++;
          $display("FAIL rand%0d_byte%0d addr=%h data=%h last=%b exp addr=%h data=%h", t, i,
                   got_addr[i], got_data[i], got_last[i], base + 32'(i), mem_byte(base + 32'(i)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
